// File: rtl/mod_settings_loader.sv
// mod_settings_loader: polls the controller BRAM mod-set flag and atomically loads
// segment, cycle, divider and repeat settings from words 0x20..0x2B.
// Define MOD_SETTINGS_VALIDATE_EN to reject loads whose frequency dividers are zero
// (ERR pulses instead of UPDATE and the outputs are held).
// Outputs switch on the clock edge that closes the COMMIT cycle; UPDATE/ERR mark that cycle.
module mod_settings_loader #(
  parameter int READ_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [7:0]  ADDR,
  input  logic [15:0] DOUT,
  output logic        MEM_WR_SEGMENT,
  output logic        REQ_RD_SEGMENT,
  output logic [15:0] CYCLE_0,
  output logic [15:0] CYCLE_1,
  output logic [31:0] FREQ_DIV_0,
  output logic [31:0] FREQ_DIV_1,
  output logic [31:0] REP_0,
  output logic [31:0] REP_1,
  output logic        UPDATE,
  output logic        ERR
);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [READ_LATENCY-1:0] r_cap_v;
  logic [READ_LATENCY-1:0] r_flag_v;
  logic [3:0] r_cap_idx [READ_LATENCY];
  logic [15:0] r_sh [12];
  logic r_prev;
  logic w_issue, w_cap_done, w_edge, w_bad;
  assign w_issue = r_state == LOAD && r_cnt < 4'd12;
  assign w_cap_done = r_cap_v[READ_LATENCY-1] && r_cap_idx[READ_LATENCY-1] == 4'd11;
  assign w_edge = r_state == IDLE && r_flag_v[READ_LATENCY-1] && DOUT[0] && !r_prev;
`ifdef MOD_SETTINGS_VALIDATE_EN
  logic [31:0] w_fd0, w_fd1;
  assign w_fd0 = {r_sh[4], r_sh[3]};
  assign w_fd1 = {r_sh[7], r_sh[6]};
  assign w_bad = w_fd0 == 32'd0 || w_fd1 == 32'd0;
`else
  assign w_bad = 1'b0;
`endif
  // state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: poll, load until the last word is captured, commit for one cycle
  always_comb begin
    w_next = r_state == IDLE ? (w_edge ? LOAD : IDLE) :
             r_state == LOAD ? (w_cap_done ? COMMIT : LOAD) : IDLE;
  end
  // outputs: flag address whenever no settings word is being issued; pulses only in COMMIT
  always_comb begin
    ADDR = w_issue ? {4'h2, r_cnt} : 8'h00;
    UPDATE = r_state == COMMIT && !RST && !w_bad;
    ERR = r_state == COMMIT && !RST && w_bad;
  end
  // read pipelines, shadow capture, flag edge history and atomic output copy
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= 4'd0;
      r_cap_v <= '0;
      r_flag_v <= '0;
      r_prev <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) r_cap_idx[i] <= 4'd0;
      for (int i = 0; i < 12; i++) r_sh[i] <= 16'd0;
      MEM_WR_SEGMENT <= 1'b0;
      REQ_RD_SEGMENT <= 1'b0;
      CYCLE_0 <= 16'd1;
      CYCLE_1 <= 16'd1;
      FREQ_DIV_0 <= 32'd5120;
      FREQ_DIV_1 <= 32'd5120;
      REP_0 <= 32'hFFFF_FFFF;
      REP_1 <= 32'hFFFF_FFFF;
    end else begin
      r_cnt <= r_state == LOAD ? r_cnt + {3'd0, w_issue} : 4'd0;
      r_cap_v[0] <= w_issue;
      r_cap_idx[0] <= r_cnt;
      r_flag_v[0] <= !w_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_cap_v[i] <= r_cap_v[i-1];
        r_cap_idx[i] <= r_cap_idx[i-1];
        r_flag_v[i] <= r_flag_v[i-1];
      end
      if (r_cap_v[READ_LATENCY-1]) r_sh[r_cap_idx[READ_LATENCY-1]] <= DOUT;
      if (r_state == IDLE && r_flag_v[READ_LATENCY-1]) r_prev <= DOUT[0];
      if (UPDATE) begin
        MEM_WR_SEGMENT <= r_sh[0][0];
        REQ_RD_SEGMENT <= r_sh[1][0];
        CYCLE_0 <= r_sh[2];
        FREQ_DIV_0 <= {r_sh[4], r_sh[3]};
        CYCLE_1 <= r_sh[5];
        FREQ_DIV_1 <= {r_sh[7], r_sh[6]};
        REP_0 <= {r_sh[9], r_sh[8]};
        REP_1 <= {r_sh[11], r_sh[10]};
      end
    end
  end
endmodule

// File: tb/tb_mod_settings_loader.sv
// tb_mod_settings_loader: scoreboard bench for the settings loader with a 2-cycle BRAM model.
module tb_mod_settings_loader;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] addr;
  logic [15:0] dout, p1;
  logic mw, rr, upd, err;
  logic [15:0] c0, c1;
  logic [31:0] f0, f1, r0, r1;
  mod_settings_loader #(.READ_LATENCY(2)) dut (
    .CLK(clk), .RST(rst), .ADDR(addr), .DOUT(dout),
    .MEM_WR_SEGMENT(mw), .REQ_RD_SEGMENT(rr),
    .CYCLE_0(c0), .CYCLE_1(c1), .FREQ_DIV_0(f0), .FREQ_DIV_1(f1),
    .REP_0(r0), .REP_1(r1), .UPDATE(upd), .ERR(err)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic mw; logic rr; logic [15:0] c0; logic [15:0] c1;
    logic [31:0] f0; logic [31:0] f1; logic [31:0] r0; logic [31:0] r1;
  } cfg_t;
  localparam cfg_t RST_CFG = '{mw: 1'b0, rr: 1'b0, c0: 16'd1, c1: 16'd1, f0: 32'd5120,
                               f1: 32'd5120, r0: 32'hFFFF_FFFF, r1: 32'hFFFF_FFFF};
  localparam cfg_t LOAD1_CFG = '{mw: 1'b1, rr: 1'b1, c0: 16'h0FFF, c1: 16'd16, f0: 32'd5120,
                                 f1: 32'd10240, r0: 32'd5, r1: 32'hFFFF_FFFF};
  logic [15:0] mem [256];
  always @(posedge clk) begin
    p1 <= mem[addr];
    dout <= p1;
  end
  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_addr [$];
  cfg_t exp_cfg [$];
  logic [7:0] addr_log [256];
  logic upd_log [256];
  logic err_log [256];
  cfg_t cfg_log [256];
  function automatic cfg_t cur();
    return {mw, rr, c0, c1, f0, f1, r0, r1};
  endfunction
  function automatic cfg_t model();
    cfg_t m;
    m.mw = mem[8'h20][0];
    m.rr = mem[8'h21][0];
    m.c0 = mem[8'h22];
    m.f0 = {mem[8'h24], mem[8'h23]};
    m.c1 = mem[8'h25];
    m.f1 = {mem[8'h27], mem[8'h26]};
    m.r0 = {mem[8'h29], mem[8'h28]};
    m.r1 = {mem[8'h2B], mem[8'h2A]};
    return m;
  endfunction
  task automatic set_words(input logic [15:0] w [12]);
    for (int k = 0; k < 12; k++) mem[8'h20 + k] = w[k];
  endtask
  task automatic push_load();
    for (int k = 0; k < 12; k++) exp_addr.push_back(8'h20 + 8'(k));
    exp_cfg.push_back(model());
  endtask
  task automatic log_at(input int i);
    addr_log[i] = addr;
    upd_log[i] = upd;
    err_log[i] = err;
    cfg_log[i] = cur();
  endtask
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      log_at(i);
    end
  endtask
  function automatic int find_t0(input int n);
    for (int i = 0; i < n; i++) if (addr_log[i] == 8'h20) return i;
    return -1;
  endfunction
  function automatic int count_upd(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(upd_log[i]);
    return c;
  endfunction
  function automatic int count_err(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(err_log[i]);
    return c;
  endfunction
  function automatic int count_starts(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(addr_log[i] == 8'h20);
    return c;
  endfunction
  function automatic int first_upd(input int n);
    for (int i = 0; i < n; i++) if (upd_log[i]) return i;
    return -1;
  endfunction
  function automatic int first_err(input int n);
    for (int i = 0; i < n; i++) if (err_log[i]) return i;
    return -1;
  endfunction
  task automatic test_reset();
    int nz = 0;
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", addr); end
    n_cmp++; if (cur() !== RST_CFG) begin n_bad++; $display("FAIL reset_cfg: got %h want %h", cur(), RST_CFG); end
    n_cmp++; if ({upd, err} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: got %b want 00", {upd, err}); end
    watch(100);
    for (int i = 0; i < 100; i++) nz += int'(addr_log[i] != 8'h00);
    n_cmp++; if (nz !== 0) begin n_bad++; $display("FAIL idle_addr: %0d nonzero cycles, want 0", nz); end
    n_cmp++; if (count_upd(100) !== 0) begin n_bad++; $display("FAIL idle_update: got %0d want 0", count_upd(100)); end
    n_cmp++; if (cfg_log[99] !== RST_CFG) begin n_bad++; $display("FAIL idle_cfg: got %h want %h", cfg_log[99], RST_CFG); end
  endtask
  task automatic test_load();
    logic [15:0] w [12] = '{16'd1, 16'd1, 16'h0FFF, 16'h1400, 16'h0000, 16'h0010,
                            16'h2800, 16'h0000, 16'd5, 16'd0, 16'hFFFF, 16'hFFFF};
    int t0;
    cfg_t e;
    set_words(w);
    push_load();
    @(negedge clk);
    mem[0] = 16'h0001;
    watch(40);
    t0 = find_t0(40);
    n_cmp++; if (t0 < 0) begin n_bad++; $display("FAIL load_start: no ADDR 20 within 40 cycles"); t0 = 0; end
    for (int k = 0; k < 12; k++) begin
      logic [7:0] ea = exp_addr.pop_front();
      n_cmp++; if (addr_log[t0+k] !== ea) begin n_bad++; $display("FAIL load_addr[%0d]: got %h want %h", k, addr_log[t0+k], ea); end
    end
    n_cmp++; if (addr_log[t0+12] !== 8'h00) begin n_bad++; $display("FAIL load_addr_end: got %h want 00", addr_log[t0+12]); end
    n_cmp++; if (cfg_log[t0+6] !== RST_CFG) begin n_bad++; $display("FAIL load_outputs_held: got %h want %h", cfg_log[t0+6], RST_CFG); end
    n_cmp++; if (first_upd(40) !== t0 + 14) begin n_bad++; $display("FAIL load_update_cycle: got %0d want %0d", first_upd(40) - t0, 14); end
    n_cmp++; if (count_upd(40) !== 1) begin n_bad++; $display("FAIL load_update_count: got %0d want 1", count_upd(40)); end
    n_cmp++; if (count_err(40) !== 0) begin n_bad++; $display("FAIL load_err: got %0d want 0", count_err(40)); end
    e = exp_cfg.pop_front();
    n_cmp++; if (cfg_log[t0+16] !== e) begin n_bad++; $display("FAIL load_cfg: got %h want %h", cfg_log[t0+16], e); end
    n_cmp++; if (cur() !== LOAD1_CFG) begin n_bad++; $display("FAIL load_values: got %h want %h", cur(), LOAD1_CFG); end
  endtask
  task automatic test_hold_and_reedge();
    cfg_t e;
    watch(60);
    n_cmp++; if (count_upd(60) !== 0) begin n_bad++; $display("FAIL hold_update: got %0d want 0", count_upd(60)); end
    n_cmp++; if (count_starts(60) !== 0) begin n_bad++; $display("FAIL hold_reload: got %0d loads want 0", count_starts(60)); end
    mem[0] = 16'h0000;
    watch(10);
    mem[8'h28] = 16'd7;
    push_load();
    mem[0] = 16'h0001;
    watch(40);
    n_cmp++; if (count_upd(40) !== 1) begin n_bad++; $display("FAIL reedge_update: got %0d want 1", count_upd(40)); end
    e = exp_cfg.pop_front();
    n_cmp++; if (cur() !== e) begin n_bad++; $display("FAIL reedge_cfg: got %h want %h", cur(), e); end
    repeat (12) void'(exp_addr.pop_front());
  endtask
  task automatic test_toggle_during_load();
    int t0 = -1;
    cfg_t e;
    mem[0] = 16'h0000;
    watch(10);
    mem[8'h22] = 16'h0123;
    push_load();
    mem[0] = 16'h0001;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (t0 >= 0 && i == t0 + 3) mem[0] = 16'h0000;
      if (t0 >= 0 && i == t0 + 6) mem[0] = 16'h0001;
      #1;
      log_at(i);
      if (t0 < 0 && addr == 8'h20) t0 = i;
    end
    n_cmp++; if (count_upd(80) !== 1) begin n_bad++; $display("FAIL toggle_update: got %0d want 1", count_upd(80)); end
    n_cmp++; if (count_starts(80) !== 1) begin n_bad++; $display("FAIL toggle_loads: got %0d want 1", count_starts(80)); end
    e = exp_cfg.pop_front();
    n_cmp++; if (cur() !== e) begin n_bad++; $display("FAIL toggle_cfg: got %h want %h", cur(), e); end
    repeat (12) void'(exp_addr.pop_front());
  endtask
  task automatic test_reset_abort(input int at);
    int t0 = -1;
    mem[0] = 16'h0000;
    watch(10);
    mem[0] = 16'h0001;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
        n_cmp++; if (addr !== 8'h00) begin n_bad++; $display("FAIL abort%0d_addr: got %h want 00", at, addr); end
        n_cmp++; if (cur() !== RST_CFG) begin n_bad++; $display("FAIL abort%0d_cfg: got %h want %h", at, cur(), RST_CFG); end
      end
      if (t0 >= 0 && i == t0 + at) begin
        rst = 1'b1;
        mem[0] = 16'h0000;
      end
      #1;
      log_at(i);
      if (t0 < 0 && addr == 8'h20) t0 = i;
    end
    n_cmp++; if (t0 < 0) begin n_bad++; $display("FAIL abort%0d_start: no load seen", at); end
    n_cmp++; if (count_upd(60) + count_err(60) !== 0) begin n_bad++; $display("FAIL abort%0d_pulses: got %0d want 0", at, count_upd(60) + count_err(60)); end
    n_cmp++; if (cur() !== RST_CFG) begin n_bad++; $display("FAIL abort%0d_final: got %h want %h", at, cur(), RST_CFG); end
  endtask
  task automatic test_zero_freq();
    int t0;
    cfg_t e;
    mem[8'h23] = 16'h0000;
    mem[8'h24] = 16'h0000;
    watch(10);
`ifdef MOD_SETTINGS_VALIDATE_EN
    e = cur();
`else
    e = model();
`endif
    exp_cfg.push_back(e);
    mem[0] = 16'h0001;
    watch(40);
    t0 = find_t0(40);
    n_cmp++; if (t0 < 0) begin n_bad++; $display("FAIL zero_start: no load seen"); t0 = 0; end
`ifdef MOD_SETTINGS_VALIDATE_EN
    n_cmp++; if (first_err(40) !== t0 + 14) begin n_bad++; $display("FAIL zero_err_cycle: got %0d want 14", first_err(40) - t0); end
    n_cmp++; if (count_upd(40) !== 0) begin n_bad++; $display("FAIL zero_update: got %0d want 0", count_upd(40)); end
`else
    n_cmp++; if (first_upd(40) !== t0 + 14) begin n_bad++; $display("FAIL zero_update_cycle: got %0d want 14", first_upd(40) - t0); end
    n_cmp++; if (count_err(40) !== 0) begin n_bad++; $display("FAIL zero_err: got %0d want 0", count_err(40)); end
    n_cmp++; if (f0 !== 32'd0) begin n_bad++; $display("FAIL zero_freq_div0: got %0d want 0", f0); end
`endif
    e = exp_cfg.pop_front();
    n_cmp++; if (cur() !== e) begin n_bad++; $display("FAIL zero_cfg: got %h want %h", cur(), e); end
  endtask
  always @(negedge clk) begin
    if (upd === 1'b1 && err === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL update_err_overlap: both high at %0t", $time);
    end
  end
  initial begin
    test_reset();
    test_load();
    test_hold_and_reedge();
    test_toggle_during_load();
    test_reset_abort(6);
    test_reset_abort(14);
    test_zero_freq();
    n_cmp++; if (exp_cfg.size() + exp_addr.size() !== 0) begin n_bad++; $display("FAIL scoreboard_leftover: %0d entries", exp_cfg.size() + exp_addr.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
